alu_operand_stage: RTL

//  ID->EX operand stage directly upstream of the 32-bit ALU (a, b, aluc -> s, z).

---
 rtl/alu_operand_stage_if.sv | 59 +++++
 rtl/alu_operand_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_if
//  Description : Bundle of decode-side, forwarding-side and ALU-side signals
//                for the ID->EX operand stage.
//                master = decode/hazard/EX environment, slave = operand stage.
//  Signals     : in_*     decoded op + valid/ready handshake
//                mem_*    MEM-stage writeback (forwarding source, priority)
//                wb_*     WB-stage writeback (forwarding source)
//                flush    kill all buffered ops
//                out_*, a, b, aluc, ill_op   head entry towards the ALU
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [RIDX-1:0] in_rs1;
  logic [RIDX-1:0] in_rs2;
  logic [XLEN-1:0] in_q1;
  logic [XLEN-1:0] in_q2;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [3:0]      in_aluc;
  logic [RIDX-1:0] in_rd;
  logic            in_wreg;
  logic            mem_wreg;
  logic [RIDX-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_wreg;
  logic [RIDX-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      aluc;
  logic [RIDX-1:0] out_rd;
  logic            out_wreg;
  logic            ill_op;

  modport master (
    output in_valid, in_rs1, in_rs2, in_q1, in_q2, in_imm, in_use_imm,
           in_aluc, in_rd, in_wreg, mem_wreg, mem_rd, mem_data,
           wb_wreg, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, a, b, aluc, out_rd, out_wreg, ill_op
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_q1, in_q2, in_imm, in_use_imm,
           in_aluc, in_rd, in_wreg, mem_wreg, mem_rd, mem_data,
           wb_wreg, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, a, b, aluc, out_rd, out_wreg, ill_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : ID->EX operand stage feeding the 32-bit ALU. Captures a
//                decoded op on valid/ready, resolves MEM/WB forwarding at
//                capture, selects b from rs2 or immediate and buffers ops in
//                a 2-entry skid FIFO. The head entry drives a/b/aluc directly.
//  Ports       : clk   rising-edge clock
//                clrn  asynchronous active-low reset
//                bus   alu_operand_stage_if.slave (handshake, forwarding,
//                      flush and head-entry outputs)
//  Config      : ALU_FWD_EN defined  -> MEM/WB forwarding (MEM over WB,
//                                       x0 never forwarded)
//                ALU_FWD_EN undefined -> operands taken from regfile values
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic                 clk,
  input  logic                 clrn,
  alu_operand_stage_if.slave   bus
);

  // Entry layout: {a, b, aluc, rd, wreg}
  localparam int c_EW = 2*XLEN + 4 + RIDX + 1;

  logic [c_EW-1:0] r_mem [0:1];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;

  // Head copy kept in dedicated registers so that the ALU-facing values
  // survive a drain or a flush unchanged.
  logic [XLEN-1:0] r_out_a;
  logic [XLEN-1:0] r_out_b;
  logic [3:0]      r_out_aluc;
  logic [RIDX-1:0] r_out_rd;
  logic            r_out_wreg;

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_b;
  logic [c_EW-1:0] w_in_entry;
  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_head_load;
  logic [c_EW-1:0] w_head_next;
  logic            w_ill;

`ifdef ALU_FWD_EN
  function automatic logic [XLEN-1:0] fwd(input logic [RIDX-1:0] r,
                                          input logic [XLEN-1:0] q);
    logic [XLEN-1:0] v;
    v = q;
    if (r != '0) begin
      if (bus.mem_wreg && (bus.mem_rd == r))
        v = bus.mem_data;
      else if (bus.wb_wreg && (bus.wb_rd == r))
        v = bus.wb_data;
    end
    return v;
  endfunction

  assign w_fwd_a = fwd(bus.in_rs1, bus.in_q1);
  assign w_fwd_b = fwd(bus.in_rs2, bus.in_q2);
`else
  logic w_fwd_unused;
  assign w_fwd_a      = bus.in_q1;
  assign w_fwd_b      = bus.in_q2;
  assign w_fwd_unused = ^{bus.in_rs1, bus.in_rs2, bus.mem_wreg, bus.mem_rd,
                          bus.mem_data, bus.wb_wreg, bus.wb_rd, bus.wb_data};
`endif

  assign w_b        = bus.in_use_imm ? bus.in_imm : w_fwd_b;
  assign w_in_entry = {w_fwd_a, w_b, bus.in_aluc, bus.in_rd, bus.in_wreg};

  assign w_in_ready = (r_count != 2'd2) && !bus.flush;
  assign w_push     = bus.in_valid && w_in_ready;
  // flush overrides pop in the sequential block
  assign w_pop      = (r_count != 2'd0) && bus.out_ready;

  // Which entry becomes the head after this edge, and whether it differs
  // from the one currently shown.
  always_comb begin
    w_head_load = 1'b0;
    w_head_next = w_in_entry;
    if (w_pop) begin
      if (r_count == 2'd2) begin
        w_head_load = 1'b1;
        w_head_next = r_mem[~r_rd_ptr];
      end else if (w_push) begin
        // single entry leaves while the new op arrives: new op is head
        w_head_load = 1'b1;
      end
    end else if (w_push && (r_count == 2'd0)) begin
      w_head_load = 1'b1;
    end
    if (bus.flush) begin
      w_head_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_out_a    <= '0;
      r_out_b    <= '0;
      r_out_aluc <= '0;
      r_out_rd   <= '0;
      r_out_wreg <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_head_load) begin
        {r_out_a, r_out_b, r_out_aluc, r_out_rd, r_out_wreg} <= w_head_next;
      end
    end
  end

  always_comb begin
    case (r_out_aluc)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000, 4'b1101: w_ill = 1'b0;
      default:                            w_ill = 1'b1;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.a         = r_out_a;
  assign bus.b         = r_out_b;
  assign bus.aluc      = r_out_aluc;
  assign bus.out_rd    = r_out_rd;
  assign bus.out_wreg  = r_out_wreg && !w_ill;
  assign bus.ill_op    = w_ill;

endmodule
`default_nettype wire
